// File: rtl/lcd_fb_arbiter_if.sv
// Write-requester handshake for the LCD frame-buffer arbiter.
// master = drawing/game logic, slave = arbiter.
interface lcd_fb_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 16
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;
   logic              wr_err;

   modport master (output wr_req, wr_addr, wr_data, input wr_gnt, wr_err);
   modport slave  (input wr_req, wr_addr, wr_data, output wr_gnt, wr_err);
endinterface

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer BRAM arbiter: scan-out reads aligned to DE have absolute priority,
// one write requester gets every remaining BRAM cycle (at most one write per 2 cycles).
module lcd_fb_arbiter #(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int H_START  = 43,
   parameter int V_START  = 12,
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [9:0]        HsyncCount,
   input  logic [8:0]        VsyncCount,
   lcd_fb_arbiter_if.slave   wr,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic [DATA_W-1:0] pix_data,
   output logic              frame_start
);
   localparam int PIXELS = H_ACTIVE * V_ACTIVE;

   // Reads start 3 cycles ahead of DE to cover address register + BRAM + pix register.
   localparam logic [9:0]        H_FIRST   = 10'(H_START - 3);
   localparam logic [9:0]        H_LAST    = 10'(H_START + H_ACTIVE - 4);
   localparam logic [8:0]        V_FIRST   = 9'(V_START);
   localparam logic [8:0]        V_LAST    = 9'(V_START + V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam logic [ADDR_W:0]   PIXELS_X  = (ADDR_W + 1)'(PIXELS);

   typedef enum logic {IDLE, ACK} state_t;

   state_t            state;
   logic              rd_slot;
   logic              frame_top;
   logic              wr_ok;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_vld;

   always_comb begin
      rd_slot   = (HsyncCount >= H_FIRST) && (HsyncCount <= H_LAST) &&
                  (VsyncCount >= V_FIRST) && (VsyncCount <= V_LAST);
      frame_top = (HsyncCount == '0) && (VsyncCount == '0);
      // Extra top bit keeps the compare correct when PIXELS == 2**ADDR_W.
      wr_ok     = {1'b0, wr.wr_addr} < PIXELS_X;
   end

   // NOTE: all state here is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         rd_addr     <= '0;
         rd_vld      <= '0;
         bram_en     <= 1'b0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_wdata  <= '0;
         pix_data    <= '0;
         frame_start <= 1'b0;
         wr.wr_gnt   <= 1'b0;
         wr.wr_err   <= 1'b0;
      end else begin
         wr.wr_gnt   <= 1'b0;
         wr.wr_err   <= 1'b0;
         bram_en     <= 1'b0;
         bram_we     <= 1'b0;
         frame_start <= frame_top;
         rd_vld      <= {rd_vld[0], rd_slot};
         pix_data    <= rd_vld[1] ? bram_rdata : '0;

         if (frame_top)
            rd_addr <= '0;
         else if (rd_slot)
            rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);

         if (rd_slot) begin
            bram_en   <= 1'b1;
            bram_addr <= rd_addr;
         end

         case (state)
            IDLE: begin
               if (wr.wr_req && !rd_slot) begin
                  bram_en    <= 1'b1;
                  bram_we    <= wr_ok;
                  bram_addr  <= wr.wr_addr;
                  bram_wdata <= wr.wr_data;
                  wr.wr_gnt  <= 1'b1;
                  wr.wr_err  <= !wr_ok;
                  state      <= ACK;
               end
            end
            // The requester needs one cycle to drop or replace its request.
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Randomized bench for lcd_fb_arbiter on a shrunken 16x6 screen, with a BRAM model,
// a position-based reference model and literal pins on the key timing points.
module tb_lcd_fb_arbiter;
   localparam int H_ACTIVE = 16;
   localparam int V_ACTIVE = 6;
   localparam int H_START  = 5;
   localparam int V_START  = 2;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 16;
   localparam int H_TOTAL  = 24;
   localparam int V_TOTAL  = 10;
   localparam int FRAME    = H_TOTAL * V_TOTAL;
   localparam int PIXELS   = H_ACTIVE * V_ACTIVE;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rstn;
   logic [9:0]        HsyncCount;
   logic [8:0]        VsyncCount;
   logic              bram_en, bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wdata, bram_rdata, pix_data;
   logic              frame_start;

   lcd_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   lcd_fb_arbiter #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_START(H_START),
      .V_START(V_START), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rstn(rstn), .HsyncCount(HsyncCount), .VsyncCount(VsyncCount),
      .wr(bus), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .pix_data(pix_data),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Single-port BRAM, read-first, 1-cycle read latency.
   logic              preload = 1'b1;
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= DATA_W'(16'h1000 + k);
      end else if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_wdata;
         bram_rdata <= mem[bram_addr];
      end
   end

   // Reference model: reads come from screen position, writes from the request rules.
   function automatic bit in_slot(input int hh, input int vv);
      return hh >= H_START - 3 && hh <= H_START + H_ACTIVE - 4 &&
             vv >= V_START && vv < V_START + V_ACTIVE;
   endfunction

   function automatic int pos_addr(input int hh, input int vv);
      return (vv - V_START) * H_ACTIVE + (hh - (H_START - 3));
   endfunction

   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                model_ready = 0;
   bit                s_rstn;
   int                s_h, s_v;
   bit                m_prev_gnt, m_v1, m_v2;
   int                m_a1;
   logic [DATA_W-1:0] m_w2;
   logic              e_en, e_we, e_gnt, e_err, e_fs;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata, e_pix;

   always @(posedge clk) begin
      s_rstn = rstn;
      s_h    = int'(HsyncCount);
      s_v    = int'(VsyncCount);
      if (preload) begin
         for (int k = 0; k < DEPTH; k++) ref_mem[k] = DATA_W'(16'h1000 + k);
      end
      if (!rstn) begin
         {e_en, e_we, e_gnt, e_err, e_fs} = '0;
         e_addr = '0; e_wdata = '0; e_pix = '0;
         m_prev_gnt = 0; m_v1 = 0; m_v2 = 0;
      end else begin
         e_pix = m_v2 ? m_w2 : '0;
         m_v2  = m_v1;
         m_w2  = ref_mem[m_a1];
         m_v1  = in_slot(s_h, s_v);
         if (m_v1) m_a1 = pos_addr(s_h, s_v);
         e_fs  = (s_h == 0 && s_v == 0);
         e_gnt = 0;
         e_err = 0;
         if (m_v1) begin
            e_en = 1; e_we = 0; e_addr = ADDR_W'(m_a1);
         end else if (bus.wr_req && !m_prev_gnt) begin
            e_en    = 1;
            e_we    = int'(bus.wr_addr) < PIXELS;
            e_addr  = bus.wr_addr;
            e_wdata = bus.wr_data;
            e_gnt   = 1;
            e_err   = !e_we;
            if (e_we) ref_mem[bus.wr_addr] = bus.wr_data;
         end else begin
            e_en = 0; e_we = 0;
         end
         m_prev_gnt = e_gnt;
      end
      model_ready = 1;
   end

   bit phase_a = 0;

   always @(negedge clk) begin
      if (model_ready) begin
         check(bram_en === e_en,       "bram_en",     bram_en,     e_en);
         check(bram_we === e_we,       "bram_we",     bram_we,     e_we);
         check(bram_addr === e_addr,   "bram_addr",   bram_addr,   e_addr);
         check(bram_wdata === e_wdata, "bram_wdata",  bram_wdata,  e_wdata);
         check(bus.wr_gnt === e_gnt,   "wr_gnt",      bus.wr_gnt,  e_gnt);
         check(bus.wr_err === e_err,   "wr_err",      bus.wr_err,  e_err);
         check(pix_data === e_pix,     "pix_data",    pix_data,    e_pix);
         check(frame_start === e_fs,   "frame_start", frame_start, e_fs);
         if (s_rstn && s_h == 2 && s_v == 2) begin
            check(bram_en === 1'b1 && bram_we === 1'b0, "first_read_en", bram_en, 1);
            check(bram_addr === 7'd0, "first_read_addr", bram_addr, 0);
         end
         if (s_rstn && s_h == 17 && s_v == 7)
            check(bram_en === 1'b1 && bram_addr === 7'd95, "last_read_addr", bram_addr, 95);
         if (phase_a && s_h == 3 && s_v == 2)
            check(pix_data === 16'h0000, "pix_before_de", pix_data, 0);
         if (phase_a && s_h == 4 && s_v == 2)
            check(pix_data === 16'h1000, "pix_de_first", pix_data, 16'h1000);
         if (phase_a && s_h == 19 && s_v == 2)
            check(pix_data === 16'h100F, "pix_de_last", pix_data, 16'h100F);
         if (phase_a && s_h == 20 && s_v == 3)
            check(pix_data === 16'h0000, "pix_blank", pix_data, 0);
      end
   end

   // Stimulus: timing generator plus a requester that holds until granted.
   int h = 0, v = 8;
   int grants = 0, fs_count = 0, b2b = 0;
   bit we_prev = 0;
   int g_h, g_v;
   bit chain_on = 0;
   int chain_i = 0;
   int chain_addr [10] = '{10, 11, 96, 12, 13, 127, 14, 15, 16, 17};

   task automatic next_cycle(input bit rand_req);
      @(negedge clk);
      if (frame_start === 1'b1) fs_count++;
      if (bram_we === 1'b1 && we_prev) b2b++;
      we_prev = (bram_we === 1'b1);
      if (bus.wr_gnt === 1'b1) begin
         grants++;
         g_h = h;
         g_v = v;
         check(bus.wr_err === (int'(bus.wr_addr) >= PIXELS), "gnt_err", bus.wr_err,
               int'(bus.wr_addr) >= PIXELS);
         check(bram_we === (int'(bus.wr_addr) < PIXELS), "gnt_we", bram_we,
               int'(bus.wr_addr) < PIXELS);
         check(bram_addr === bus.wr_addr && bram_wdata === bus.wr_data, "gnt_addr_data",
               {bram_addr, bram_wdata}, {bus.wr_addr, bus.wr_data});
         if (chain_on && chain_i < 9) begin
            chain_i++;
            bus.wr_addr = ADDR_W'(chain_addr[chain_i]);
            bus.wr_data = DATA_W'(16'hC000 + chain_i);
         end else begin
            bus.wr_req = 1'b0;
         end
      end
      if (rand_req && !bus.wr_req && $urandom_range(0, 3) == 0) begin
         bus.wr_req  = 1'b1;
         bus.wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         bus.wr_data = DATA_W'($urandom);
      end
      h++;
      if (h == H_TOTAL) begin
         h = 0;
         v = (v + 1) % V_TOTAL;
      end
      HsyncCount = 10'(h);
      VsyncCount = 9'(v);
   endtask

   task automatic run_to(input int th, input int tv, input string name);
      int n = 0;
      while (!(h == th && v == tv) && n < 2 * FRAME) begin
         next_cycle(0);
         n++;
      end
      check(h == th && v == tv, name, n, 0);
   endtask

   initial begin
      int g0, bad;
      rstn = 1'b0;
      HsyncCount = 10'(h);
      VsyncCount = 9'(v);
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      repeat (3) next_cycle(0);
      preload = 1'b0;
      check(bram_en === 1'b0 && bram_addr === '0 && pix_data === '0 && frame_start === 1'b0
            && bus.wr_gnt === 1'b0, "reset_state", {bram_en, bram_addr, pix_data}, 0);
      rstn = 1'b1;

      // Two idle frames over the preloaded image.
      phase_a = 1;
      fs_count = 0;
      repeat (2 * FRAME) next_cycle(0);
      phase_a = 0;
      check(fs_count == 2, "frame_start_count", fs_count, 2);

      // Request raised mid active line waits for the first non-read cycle.
      run_to(10, 3, "reach_active_line");
      bus.wr_req = 1'b1; bus.wr_addr = 7'h20; bus.wr_data = 16'hF800;
      g0 = grants;
      for (int n = 0; n < 40 && grants == g0; n++) next_cycle(0);
      check(grants == g0 + 1 && g_h == 18 && g_v == 3, "first_grant_pos", g_h, 18);
      repeat (4) next_cycle(0);
      check(grants == g0 + 1, "single_grant", grants - g0, 1);
      check(mem[32] === 16'hF800, "bram_written", mem[32], 16'hF800);

      // Continuous request in vertical blank, including out-of-range addresses.
      run_to(0, 8, "reach_vblank");
      chain_on = 1; chain_i = 0; b2b = 0;
      bus.wr_req = 1'b1;
      bus.wr_addr = ADDR_W'(chain_addr[0]);
      bus.wr_data = 16'hC000;
      g0 = grants;
      repeat (20) next_cycle(0);
      chain_on = 0;
      check(grants - g0 == 10, "vblank_grant_rate", grants - g0, 10);
      check(b2b == 0, "no_back_to_back_we", b2b, 0);
      repeat (2) next_cycle(0);
      check(mem[96] === 16'h1060, "oob_unchanged_96", mem[96], 16'h1060);
      check(mem[127] === 16'h107F, "oob_unchanged_127", mem[127], 16'h107F);
      check(mem[10] === 16'hC000 && mem[17] === 16'hC009, "chain_written", mem[17], 16'hC009);

      // Random traffic over several frames.
      repeat (6 * FRAME) next_cycle(1);

      // Reset mid blank line with a request raised in the same cycle.
      for (int n = 0; n < 100 && bus.wr_req; n++) next_cycle(0);
      check(!bus.wr_req, "drain_request", bus.wr_req, 0);
      run_to(10, 8, "reach_reset_point");
      bus.wr_req = 1'b1; bus.wr_addr = 7'd5; bus.wr_data = 16'hBEEF;
      rstn = 1'b0;
      g0 = grants;
      next_cycle(0);
      check(bram_en === 1'b0 && bram_we === 1'b0 && bram_addr === '0 && bram_wdata === '0,
            "reset_bram_zero", {bram_en, bram_we, bram_addr, bram_wdata}, 0);
      check(bus.wr_gnt === 1'b0 && bus.wr_err === 1'b0 && pix_data === '0
            && frame_start === 1'b0, "reset_out_zero", {bus.wr_gnt, pix_data}, 0);
      check(grants == g0, "no_gnt_in_reset", grants - g0, 0);
      rstn = 1'b1;
      next_cycle(0);
      check(grants == g0 + 1, "gnt_after_reset", grants - g0, 1);
      repeat (300) next_cycle(0);

      repeat (2) next_cycle(0);
      bad = 0;
      for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) bad++;
      check(bad == 0, "bram_contents", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
